// File: rtl/onehot_sweep_gen.sv
// One-hot sweep stimulus generator: delivers every bit position exactly once over valid/ready,
// holding GATED_BIT back until one of its prerequisites was accepted at least GAP cycles earlier.
module onehot_sweep_gen #(
    parameter int WIDTH     = 105,
    parameter int GATED_BIT = 89,
    parameter int PREREQ_A  = 96,
    parameter int PREREQ_B  = 101,
    parameter int GAP       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    output logic             x_valid,
    input  logic             x_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] coverage,
    output logic             busy,
    output logic             done
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IW-1:0]    FIRST_IDX = {IW{1'b0}};
    localparam logic [IW-1:0]    LAST_IDX  = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    GATED_IDX = IW'(GATED_BIT);
    localparam logic [CW-1:0]    CNT_MAX   = CW'(GAP - 1);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic is_last(input logic [IW-1:0] pos, input logic d);
        if (d) begin
            is_last = (pos == FIRST_IDX);
        end else begin
            is_last = (pos == LAST_IDX);
        end
    endfunction

    function automatic logic [IW-1:0] step(input logic [IW-1:0] pos, input logic d);
        if (d) begin
            step = pos - IW'(1);
        end else begin
            step = pos + IW'(1);
        end
    endfunction

    function automatic logic [WIDTH-1:0] onehot(input logic [IW-1:0] pos);
        onehot = ONE_W << pos;
    endfunction

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             deferred_q, deferred_d;
    logic             prereq_seen_q, prereq_seen_d;
    logic [CW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] coverage_q, coverage_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             xfer_s;
    logic             start_s;
    logic             elig_s;
    logic             adv_s;
    logic             adv_dir_s;
    logic             cand_ok_s;
    logic [IW-1:0]    cand_s;
    logic             skip_s;
    logic             next_ok_s;
    logic [IW-1:0]    next_pos_s;
    logic [WIDTH-1:0] flush_word_s;

    // Next-state, gating bookkeeping and next registered outputs.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dir_d         = dir_q;
        deferred_d    = deferred_q;
        prereq_seen_d = prereq_seen_q;
        gap_cnt_d     = gap_cnt_q;
        coverage_d    = coverage_q;
        x_d           = ZERO_W;
        x_valid_d     = 1'b0;
        adv_s         = 1'b0;
        cand_ok_s     = 1'b0;
        cand_s        = idx_q;

        xfer_s  = x_valid_q && x_ready;
        start_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        // The counter restarts only on the first prerequisite of a sweep and then saturates.
        if (start_s) begin
            prereq_seen_d = 1'b0;
            gap_cnt_d     = {CW{1'b0}};
        end else if (xfer_s && !prereq_seen_q && (x_q[PREREQ_A] || x_q[PREREQ_B])) begin
            prereq_seen_d = 1'b1;
            gap_cnt_d     = {CW{1'b0}};
        end else if (prereq_seen_q && (gap_cnt_q != CNT_MAX)) begin
            gap_cnt_d = gap_cnt_q + CW'(1);
        end else begin
            gap_cnt_d = gap_cnt_q;
        end
        // Eligibility is judged for the cycle the next registered word will be on the bus.
        elig_s       = prereq_seen_d && (gap_cnt_d == CNT_MAX);
        flush_word_s = elig_s ? onehot(GATED_IDX) : ZERO_W;

        if (xfer_s) begin
            coverage_d = coverage_q | x_q;
        end else begin
            coverage_d = coverage_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_s) begin
                    dir_d      = dir;
                    deferred_d = 1'b0;
                    coverage_d = ZERO_W;
                    adv_s      = 1'b1;
                    cand_ok_s  = 1'b1;
                    cand_s     = dir ? LAST_IDX : FIRST_IDX;
                end else begin
                    adv_s = 1'b0;
                end
            end
            S_SWEEP: begin
                if (xfer_s) begin
                    adv_s     = 1'b1;
                    cand_ok_s = !is_last(idx_q, dir_q);
                    cand_s    = step(idx_q, dir_q);
                end else begin
                    x_valid_d = 1'b1;
                    x_d       = x_q;
                end
            end
            S_FLUSH: begin
                if (xfer_s) begin
                    state_d = S_DONE;
                end else begin
                    x_valid_d = elig_s;
                    x_d       = flush_word_s;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A gated candidate that is not yet eligible is stepped over within the same cycle.
        adv_dir_s  = start_s ? dir : dir_q;
        skip_s     = adv_s && cand_ok_s && (cand_s == GATED_IDX) && !elig_s;
        next_ok_s  = cand_ok_s && !(skip_s && is_last(cand_s, adv_dir_s));
        next_pos_s = skip_s ? step(cand_s, adv_dir_s) : cand_s;

        if (adv_s) begin
            if (skip_s) begin
                deferred_d = 1'b1;
            end else begin
                deferred_d = deferred_d;
            end
            if (next_ok_s) begin
                state_d   = S_SWEEP;
                idx_d     = next_pos_s;
                x_valid_d = 1'b1;
                x_d       = onehot(next_pos_s);
            end else if (deferred_d) begin
                state_d   = S_FLUSH;
                x_valid_d = elig_s;
                x_d       = flush_word_s;
            end else begin
                state_d = S_DONE;
            end
        end else begin
            idx_d = idx_d;
        end

        busy_d = (state_d == S_SWEEP) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= {IW{1'b0}};
            dir_q         <= 1'b0;
            deferred_q    <= 1'b0;
            prereq_seen_q <= 1'b0;
            gap_cnt_q     <= {CW{1'b0}};
            coverage_q    <= ZERO_W;
            x_q           <= ZERO_W;
            x_valid_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            dir_q         <= dir_d;
            deferred_q    <= deferred_d;
            prereq_seen_q <= prereq_seen_d;
            gap_cnt_q     <= gap_cnt_d;
            coverage_q    <= coverage_d;
            x_q           <= x_d;
            x_valid_q     <= x_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign x_valid  = x_valid_q;
    assign x        = x_q;
    assign coverage = coverage_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_onehot_sweep_gen.sv
// Scoreboard bench for onehot_sweep_gen: default 105-bit instance plus a 4-bit gating instance.
module tb_onehot_sweep_gen;
    localparam int W  = 105;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          start, dir, x_ready, x_valid, busy, done;
    logic [W-1:0]  x, coverage;
    logic          s_start, s_dir, s_x_ready, s_x_valid, s_busy, s_done;
    logic [SW-1:0] s_x, s_coverage;

    int errors = 0;
    int checks = 0;
    int exp_bit_q[$];
    int exp_cyc_q[$];
    logic [W-1:0] one_w;
    logic [W-1:0] ones_w;

    onehot_sweep_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
        .x_valid(x_valid), .x_ready(x_ready), .x(x),
        .coverage(coverage), .busy(busy), .done(done)
    );

    onehot_sweep_gen #(.WIDTH(4), .GATED_BIT(0), .PREREQ_A(3), .PREREQ_B(2), .GAP(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .dir(s_dir),
        .x_valid(s_x_valid), .x_ready(s_x_ready), .x(s_x),
        .coverage(s_coverage), .busy(s_busy), .done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Start a sweep on the big instance; pops the scoreboard on every accepted word.
    task automatic run_big(input logic d, input bit rnd, output int n_xfer, output int done_cyc,
                           output int prereq_cyc, output int gated_cyc);
        bit stalled;
        bit rdy;
        logic [W-1:0] held;
        logic [W-1:0] ew;
        int eb;
        int ec;
        n_xfer = 0; done_cyc = -1; prereq_cyc = -1; gated_cyc = -1;
        stalled = 1'b0; held = '0;
        @(negedge clk);
        start = 1'b1; dir = d; x_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (coverage !== '0 || done !== 1'b0 || busy !== 1'b1 || x_valid !== 1'b1) begin
            errors++;
            $display("FAIL sweep_start: valid=%b busy=%b done=%b cov=%h, required valid=1 busy=1 done=0 cov=0",
                     x_valid, busy, done, coverage);
        end
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (stalled) begin
                checks++;
                if (x_valid !== 1'b1 || x !== held) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d: valid=%b x=%h, required valid=1 x=%h", cyc, x_valid, x, held);
                end
            end
            checks++;
            if (x_valid === 1'b1) begin
                if ($countones(x) != 1) begin
                    errors++;
                    $display("FAIL onehot cyc=%0d: x=%h, required exactly one bit set", cyc, x);
                end
            end else if (x !== '0) begin
                errors++;
                $display("FAIL idle_zero cyc=%0d: x=%h, required 0", cyc, x);
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            x_ready = rdy;
            stalled = (x_valid === 1'b1) && !rdy;
            held = x;
            if (x_valid === 1'b1 && rdy) begin
                n_xfer++;
                if (prereq_cyc < 0 && (x[96] === 1'b1 || x[101] === 1'b1)) prereq_cyc = cyc;
                if (x[89] === 1'b1) gated_cyc = cyc;
                checks++;
                if (exp_bit_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_xfer cyc=%0d: x=%h, required no further transfer", cyc, x);
                end else begin
                    eb = exp_bit_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    ew = one_w << eb;
                    if (x !== ew || (ec >= 0 && ec != cyc)) begin
                        errors++;
                        $display("FAIL xfer cyc=%0d: x=%h, required bit %0d at cycle %0d", cyc, x, eb, ec);
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; x_ready = 1'b0;
        s_start = 1'b0; s_dir = 1'b0; s_x_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (x_valid !== 1'b0 || x !== '0 || coverage !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            s_x_valid !== 1'b0 || s_x !== '0 || s_coverage !== '0 || s_busy !== 1'b0 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b x=%h cov=%h busy=%b done=%b, required all zero",
                     x_valid, x, coverage, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ascending();
        int n, dc, pc, gc;
        exp_bit_q.delete(); exp_cyc_q.delete();
        for (int b = 0; b <= 88; b++) begin exp_bit_q.push_back(b); exp_cyc_q.push_back(b + 1); end
        for (int b = 90; b <= 104; b++) begin exp_bit_q.push_back(b); exp_cyc_q.push_back(b); end
        exp_bit_q.push_back(89); exp_cyc_q.push_back(105);
        run_big(1'b0, 1'b0, n, dc, pc, gc);
        checks++;
        if (dc != 106 || n != 105 || coverage !== ones_w || exp_bit_q.size() != 0) begin
            errors++;
            $display("FAIL ascending_end: done_cyc=%0d xfers=%0d left=%0d cov=%h, required 106 105 0 all-ones",
                     dc, n, exp_bit_q.size(), coverage);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || x_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: done=%b valid=%b busy=%b, required 1 0 0", done, x_valid, busy);
        end
    endtask

    task automatic test_descending();
        int n, dc, pc, gc;
        exp_bit_q.delete(); exp_cyc_q.delete();
        for (int b = 104; b >= 0; b--) begin exp_bit_q.push_back(b); exp_cyc_q.push_back(105 - b); end
        run_big(1'b1, 1'b0, n, dc, pc, gc);
        checks++;
        if (dc != 106 || n != 105 || coverage !== ones_w || exp_bit_q.size() != 0 || gc - pc != 12) begin
            errors++;
            $display("FAIL descending_end: done_cyc=%0d xfers=%0d left=%0d gap=%0d, required 106 105 0 12",
                     dc, n, exp_bit_q.size(), gc - pc);
        end
    endtask

    task automatic test_backpressure();
        int n, dc, pc, gc;
        exp_bit_q.delete(); exp_cyc_q.delete();
        for (int b = 0; b <= 104; b++) begin
            if (b != 89) begin exp_bit_q.push_back(b); exp_cyc_q.push_back(-1); end
        end
        exp_bit_q.push_back(89); exp_cyc_q.push_back(-1);
        run_big(1'b0, 1'b1, n, dc, pc, gc);
        checks++;
        if (dc < 0 || n != 105 || coverage !== ones_w || exp_bit_q.size() != 0 || pc < 0 || gc - pc < 2) begin
            errors++;
            $display("FAIL backpressure_end: done_cyc=%0d xfers=%0d left=%0d prereq=%0d gated=%0d, required done 105 0 gap>=2",
                     dc, n, exp_bit_q.size(), pc, gc);
        end
    endtask

    task automatic test_small_gating();
        int order[4] = '{1, 2, 3, 0};
        int when[4]  = '{1, 2, 3, 5};
        int dc;
        int eb, ec;
        logic [SW-1:0] ew;
        exp_bit_q.delete(); exp_cyc_q.delete();
        for (int i = 0; i < 4; i++) begin exp_bit_q.push_back(order[i]); exp_cyc_q.push_back(when[i]); end
        dc = -1;
        @(negedge clk);
        s_start = 1'b1; s_dir = 1'b0; s_x_ready = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (s_done === 1'b1) begin
                dc = cyc;
                break;
            end
            if (cyc == 4) begin
                checks++;
                if (s_x_valid !== 1'b0 || s_x !== '0) begin
                    errors++;
                    $display("FAIL small_flush_wait: valid=%b x=%h, required 0 0", s_x_valid, s_x);
                end
            end
            if (s_x_valid === 1'b1) begin
                checks++;
                if (exp_bit_q.size() == 0) begin
                    errors++;
                    $display("FAIL small_extra cyc=%0d: x=%h, required no transfer", cyc, s_x);
                end else begin
                    eb = exp_bit_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    ew = SW'(1) << eb;
                    if (s_x !== ew || ec != cyc) begin
                        errors++;
                        $display("FAIL small_xfer cyc=%0d: x=%h, required bit %0d at cycle %0d", cyc, s_x, eb, ec);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dc != 6 || s_coverage !== 4'hF || exp_bit_q.size() != 0) begin
            errors++;
            $display("FAIL small_end: done_cyc=%0d cov=%h left=%0d, required 6 f 0", dc, s_coverage, exp_bit_q.size());
        end
    endtask

    task automatic test_control();
        logic [W-1:0] ew;
        @(negedge clk);
        start = 1'b1; dir = 1'b0; x_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        ew = one_w << 4;
        checks++;
        if (x !== ew) begin
            errors++;
            $display("FAIL ctrl_cycle5: x=%h, required %h", x, ew);
        end
        start = 1'b1; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ew = one_w << 5;
        checks++;
        if (x !== ew || busy !== 1'b1 || coverage !== 105'h1F) begin
            errors++;
            $display("FAIL start_ignored: x=%h busy=%b cov=%h, required x=%h busy=1 cov=1f", x, busy, coverage, ew);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (x_valid !== 1'b0 || x !== '0 || coverage !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b x=%h cov=%h busy=%b done=%b, required all zero",
                     x_valid, x, coverage, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || x_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b valid=%b done=%b, required 0 0 0", busy, x_valid, done);
        end
    endtask

    initial begin
        one_w  = {{(W-1){1'b0}}, 1'b1};
        ones_w = {W{1'b1}};
        test_reset();
        test_ascending();
        test_descending();
        test_backpressure();
        test_small_gating();
        test_control();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onehot_sweep_gen.md
Name: onehot_sweep_gen

Overview:
- Stimulus transmitter for the one-hot latch harness.
- Emits a sequence of one-hot WIDTH-bit words over a valid/ready handshake until every bit position has been delivered exactly once.
- Enforces the harness ordering rule: the gated bit is sent only after one of its two prerequisite bits was accepted at least GAP cycles earlier.
- Maintains a running coverage vector and raises done once all bits are covered.

Parameters:
- WIDTH, 105: word width and number of bit positions to cover.
- GATED_BIT, 89: index whose delivery is ordering-constrained.
- PREREQ_A, 96: first prerequisite index.
- PREREQ_B, 101: second prerequisite index.
- GAP, 2: minimum cycles between the first prerequisite handshake and the gated-bit handshake (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a sweep when in IDLE or DONE
- dir  input  1  sampled on accepted start; 0 = ascending from index 0, 1 = descending from WIDTH-1
- x_valid  output  1  word on x is valid
- x_ready  input  1  receiver accepts x this cycle
- x  output  WIDTH  one-hot word; all zeros when x_valid=0
- coverage  output  WIDTH  OR of all accepted words in the current sweep
- busy  output  1  high in SWEEP or FLUSH
- done  output  1  high in DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - x_valid=0, x=0, coverage=0, busy=0, done=0.
  - idx=0, deferred=0, prereq_seen=0, gap counter=0.
- Handshake:
  - A transfer occurs when x_valid && x_ready.
  - While x_valid=1 and x_ready=0, x holds stable.
  - x_valid never drops without a transfer, except on reset.
  - On a transfer, coverage |= x at the clock edge.
- FSM states: IDLE, SWEEP, FLUSH, DONE.
- IDLE/DONE + start=1:
  - Latch dir, clear coverage, set idx to 0 (dir=0) or WIDTH-1 (dir=1), clear deferred, clear prereq_seen.
  - Enter SWEEP; x_valid=1 on the next cycle (1-cycle latency from start).
  - done drops in the same edge.
- start while busy: ignored, no effect.
- SWEEP:
  - x = 1<<idx.
  - On a transfer, advance idx by +1 or -1.
  - If the next idx equals GATED_BIT and the gating rule is not met, skip it in the same step at zero cycle cost and set deferred=1.
  - Advancing past the last index (WIDTH-1 ascending, 0 descending):
    - Enter FLUSH if deferred=1.
    - Otherwise enter DONE.
- Gating rule:
  - The first transfer of PREREQ_A or PREREQ_B sets prereq_seen and zeroes a saturating cycle counter; the counter increments each cycle afterwards.
  - The gated bit is eligible only when prereq_seen && counter >= GAP-1, i.e. its transfer occurs >= GAP cycles after the prerequisite transfer.
- FLUSH:
  - x_valid=0 until the gating rule is met.
  - Then x = 1<<GATED_BIT with x_valid=1.
  - On transfer, enter DONE.
- DONE:
  - done=1, x_valid=0; coverage must equal all ones.
  - Held until start or reset.
- With x_ready tied high, a sweep completes in exactly WIDTH transfer cycles, plus any FLUSH wait cycles.
- Invariants:
  - x is one-hot whenever x_valid=1.
  - No bit is sent twice per sweep.
  - The gated bit is never sent before GAP cycles have elapsed after a prerequisite.
- Reset mid-sweep aborts immediately to the reset values above; coverage is lost.
- start asserted on the same cycle that DONE is entered: ignored, because state was FLUSH/SWEEP when sampled.

Test Plan:
- Ascending sweep:
  - start at cycle 0, dir=0, x_ready=1.
  - Bits 0..88 on cycles 1..89, then 90..104 on cycles 90..104, bit 89 on cycle 105.
  - done=1 at cycle 106; coverage all ones.
- Descending sweep:
  - start, dir=0→1, x_ready=1.
  - Bits 104..0 in order, 89 in natural position (101 accepted 12 cycles earlier); FLUSH never entered.
  - done after 105 transfers.
- Backpressure:
  - Ascending, x_ready random 50%.
  - x stable while stalled; exactly 105 transfers; each bit once; 89 last.
  - Gap check passes.
- Small-config gating:
  - WIDTH=4, GATED_BIT=0, PREREQ_A=3, PREREQ_B=2, GAP=3, ascending, x_ready=1.
  - Order 1,2,3 (prereq 2 at cycle 2).
  - FLUSH holds x_valid=0 for one cycle; bit 0 sent at cycle 5.
- Control:
  - start pulsed mid-sweep: ignored.
  - rst_n low mid-sweep: all outputs 0 immediately.
  - start from DONE: coverage cleared and a new sweep begins.
